uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver that turns the asynchronous serial input pin into a byte stream with a valid/ready handshake. It sits directly upstream of the BIOS command parser and drives that parser's `rx_data`/`rx_valid` inputs, taking `rx_ready` back from it. Bit timing comes from the shared baud-rate enable `clk_en`, which pulses at OVERSAMPLE × baud rate. Framing errors and overruns are flagged as one-cycle pulses.

## Interface
- `OVERSAMPLE`, default 16: `clk_en` ticks per bit. Must be even and ≥ 4.
- `DATA_BITS`, default 8: data bits per frame. Frame is 1 start bit, `DATA_BITS` data bits LSB first, 1 stop bit, no parity.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-low reset.
- `clk_en` in 1: oversample tick, one `clk` cycle wide.
- `rxd` in 1: asynchronous serial line; idles high.
- `rx_data` out `DATA_BITS`: received byte; stable while `rx_valid` = 1.
- `rx_valid` out 1: byte available.
- `rx_ready` in 1: consumer accepts the byte.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a completed byte is dropped.

## Operation
- **Input synchronizer**
  - `rxd` passes through a 2-flop synchronizer; the synchronized signal is `rxs`.
  - Both flops reset to 1.
- **Reset state**
  - Synchronizer flops = 1, `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - State = IDLE, tick counter = 0, bit index = 0, shift register = 0.
- **State machine.** It advances only on cycles where `clk_en` = 1. `cnt` is the tick counter, 0..OVERSAMPLE-1.
  - IDLE: on a tick with `rxs` = 0, go to START with `cnt` = 0.
  - START: increment `cnt` each tick. At the tick where `cnt` = OVERSAMPLE/2-1, sample the line:
    - sample 0: go to DATA, `cnt` = 0, bit index = 0;
    - sample 1: glitch; go to IDLE with no output.
  - DATA: increment `cnt` each tick. At `cnt` = OVERSAMPLE-1:
    - shift the sample into the MSB of the shift register (right shift), `cnt` = 0, bit index + 1;
    - after bit DATA_BITS-1 is shifted in, go to STOP.
  - STOP: at `cnt` = OVERSAMPLE-1, sample the line:
    - sample 1: deliver the byte and go to IDLE;
    - sample 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: on a tick with `rxs` = 1, go to IDLE. This keeps a break condition from producing repeated frames.
- **Delivery and handshake.** Handshake rules are evaluated on every `clk` edge; they are not gated by `clk_en`.
  - Delivery when `rx_valid` = 0: load `rx_data`, set `rx_valid` = 1.
  - Delivery in the same cycle as `rx_valid & rx_ready`: load the new byte and keep `rx_valid` = 1.
  - Delivery when `rx_valid` = 1 and `rx_ready` = 0: keep the old byte and pulse `overrun`.
  - `rx_valid & rx_ready` with no delivery: clear `rx_valid`. `rx_data` keeps its last value.
- `frame_err` and `overrun` are never asserted together for the same frame.

## Timing
- Synchronizer latency: 2 `clk` cycles from an `rxd` edge to `rxs`.
- `rx_valid` rises on the `clk` edge of the stop-bit sample tick. `rx_data` is registered in that same edge.
- `frame_err` and `overrun` are high for exactly one `clk` cycle: the cycle after the stop-bit sample edge.
- Stop-bit sampling is at mid-bit, so a new start bit is accepted from the tick after the stop-bit sample. Back-to-back frames therefore need no extra idle time.
- Reset asserted mid-frame: all state returns to reset values on the next edge, and the partial byte is lost. After reset releases, a line that is still low enters START on the first tick.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Every sample point (start check, data bits, stop bit) uses the majority of 3 `rxs` values.
  - The 3 values are taken on the sample tick and the two preceding ticks.
  - A 3-bit history register is updated on every tick.
- Not defined: each sample point uses the single `rxs` value on the sample tick, and no history register exists.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_t` enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - Default oversample constant `UART_OVERSAMPLE` = 16.
- One sub-module: `sync2`, a generic 2-flop synchronizer with a reset-value parameter. It is reused for any other asynchronous pin.

## Test plan
- Send frame 0x55 at 16× with `rx_ready` held at 1 → one `rx_valid` pulse with `rx_data` = 0x55; no error pulses.
- Drive `rxd` low for 4 ticks, then high → no `rx_valid`, no `frame_err`; state back in IDLE.
- Send 0xA3 with the stop bit low → one `frame_err` pulse, no `rx_valid`. The next byte is accepted only after the line has been high for at least one tick.
- Send 0x12 then 0x34 with `rx_ready` = 0 → `rx_data` stays 0x12 and `overrun` pulses once. Then raise `rx_ready` for one cycle → `rx_valid` drops.
- Assert `rst` low in the middle of data bit 4 of 0xFF, then release it with the line high → all outputs 0. A following 0x0F is received correctly.
- With `UART_RX_MAJORITY_EN`, send 0x00 with a 1-tick high glitch on the centre sample of bit 2 → `rx_data` = 0x00.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
//   uart_rx_state_t : receiver state encoding
//   UART_OVERSAMPLE : default clk_en ticks per bit
//   majority3       : 2-of-3 vote used when UART_RX_MAJORITY_EN is defined
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE = 16;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- byte handshake between the UART receiver and its consumer.
//   rx_data   : received byte, stable while rx_valid is high
//   rx_valid  : byte available
//   rx_ready  : consumer accepts the byte
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, completed byte dropped
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (output rx_data, output rx_valid, output frame_err,
                  output overrun, input rx_ready);
  modport slave  (input rx_data, input rx_valid, input frame_err,
                  input overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_sync2.sv
// sync2 -- generic two-flop synchronizer for an asynchronous input pin.
//   clk : destination clock
//   rst : synchronous, active-low reset; both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles behind d
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_r;
  logic sync_r;

  // Two-stage capture; meta_r may go metastable, sync_r is the settled copy
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
endmodule

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver (1 start, DATA_BITS data LSB first,
// 1 stop, no parity) with a valid/ready byte handshake.
//   clk    : single clock
//   rst    : synchronous, active-low reset
//   clk_en : oversample tick, OVERSAMPLE ticks per bit
//   rxd    : asynchronous serial line, idles high
//   rx_bus : uart_rx_if.master (rx_data, rx_valid, rx_ready, frame_err, overrun)
// Build option: UART_RX_MAJORITY_EN -- each sample point takes the 2-of-3
// majority of the line over the sample tick and the two ticks before it.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        rxd,
  uart_rx_if.master   rx_bus
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_rx_state_t       state_r, state_n;
  logic [CNT_W-1:0]     cnt_r, cnt_n;
  logic [BIT_W-1:0]     bit_idx_r, bit_idx_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 rxs_s;
  logic                 sample_s;
  logic                 deliver_s;
  logic                 stop_bad_s;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist_r;

  // Line history at tick rate; the vote window is the current tick plus two older ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_r <= 3'b111;
    end else if (clk_en) begin
      hist_r <= {hist_r[1:0], rxs_s};
    end
  end

  assign sample_s = majority3({hist_r[1:0], rxs_s});
`else
  assign sample_s = rxs_s;
`endif

  // Frame state machine: next state, counters, shift data and frame-end events
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    bit_idx_n  = bit_idx_r;
    shift_n    = shift_r;
    deliver_s  = 1'b0;
    stop_bad_s = 1'b0;
    if (clk_en) begin
      case (state_r)
        IDLE: begin
          if (!rxs_s) begin
            state_n = START;
            cnt_n   = CNT_ZERO;
          end else begin
            state_n = IDLE;
          end
        end
        START: begin
          if (cnt_r == CNT_MID) begin
            cnt_n = CNT_ZERO;
            if (!sample_s) begin
              state_n   = DATA;
              bit_idx_n = BIT_ZERO;
            end else begin
              state_n = IDLE;  // start bit did not hold to mid-bit: glitch
            end
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_n     = CNT_ZERO;
            shift_n   = {sample_s, shift_r[DATA_BITS-1:1]};
            bit_idx_n = bit_idx_r + BIT_ONE;
            if (bit_idx_r == BIT_LAST) begin
              state_n = STOP;
            end else begin
              state_n = DATA;
            end
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_n = CNT_ZERO;
            if (sample_s) begin
              deliver_s = 1'b1;
              state_n   = IDLE;
            end else begin
              stop_bad_s = 1'b1;
              state_n    = WAIT_HIGH;  // hold off until a break ends
            end
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (rxs_s) begin
            state_n = IDLE;
          end else begin
            state_n = WAIT_HIGH;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = CNT_ZERO;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Frame state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= BIT_ZERO;
      shift_r   <= {DATA_BITS{1'b0}};
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      bit_idx_r <= bit_idx_n;
      shift_r   <= shift_n;
    end
  end

  // Output handshake, evaluated every clk; a delivery into a full, unaccepted slot is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data_r   <= {DATA_BITS{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= stop_bad_s;
      overrun_r   <= 1'b0;
      if (deliver_s) begin
        if (!rx_valid_r || rx_bus.rx_ready) begin
          rx_data_r  <= shift_r;
          rx_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (rx_valid_r && rx_bus.rx_ready) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data   = rx_data_r;
  assign rx_bus.rx_valid  = rx_valid_r;
  assign rx_bus.frame_err = frame_err_r;
  assign rx_bus.overrun   = overrun_r;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed testbench for uart_rx at 16x oversampling, 8 data bits.
// clk_en ticks once every 4 clk cycles. Line changes are driven 1 time unit
// after a tick edge, so the DUT sees each change on the following tick.
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic rxd;

  int total = 0;
  int bad   = 0;

  // event counters kept by the monitor
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_ovr   = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_valid = 1'b0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .rxd    (rxd),
    .rx_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    clk_en = 1'b0;
    forever begin
      repeat (3) begin
        @(negedge clk);
        clk_en = 1'b0;
      end
      @(negedge clk);
      clk_en = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.frame_err === 1'b1) n_ferr++;
      if (bus.overrun === 1'b1) n_ovr++;
      if (bus.rx_valid === 1'b1 && prev_valid !== 1'b1) begin
        n_valid++;
        last_data = bus.rx_data;
      end
      prev_valid = bus.rx_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_tick();
    int guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (clk_en !== 1'b1 && guard < 50);
    if (guard >= 50) begin
      $display("FAIL tick_timeout: no clk_en within %0d cycles", guard);
      $fatal(1, "clk_en missing");
    end
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) hold(d[i], 16);
    hold(stop_bit, 16);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxd = 1'b1;
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", bus.overrun); end
    @(negedge clk);
    rst = 1'b1;
    hold(1'b1, 4);
  endtask

  task automatic test_frame();
    int bv, bf, bo;
    bus.rx_ready = 1'b1;
    bv = n_valid; bf = n_ferr; bo = n_ovr;
    send_frame(8'h55, 1'b1);
    hold(1'b1, 4);
    total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL frame55_count: got %0d want 1", n_valid - bv); end
    total++; if (last_data !== 8'h55) begin bad++; $display("FAIL frame55_data: got %h want 55", last_data); end
    total++; if (n_ferr - bf !== 0) begin bad++; $display("FAIL frame55_ferr: got %0d want 0", n_ferr - bf); end
    total++; if (n_ovr - bo !== 0) begin bad++; $display("FAIL frame55_ovr: got %0d want 0", n_ovr - bo); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL frame55_accepted: got %b want 0", bus.rx_valid); end
    bv = n_valid;
    send_frame(8'hC3, 1'b1);
    hold(1'b1, 4);
    total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL frameC3_count: got %0d want 1", n_valid - bv); end
    total++; if (last_data !== 8'hC3) begin bad++; $display("FAIL frameC3_data: got %h want c3", last_data); end
  endtask

  task automatic test_glitch();
    int bv, bf;
    bv = n_valid; bf = n_ferr;
    hold(1'b0, 4);
    hold(1'b1, 24);
    total++; if (n_valid - bv !== 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", n_valid - bv); end
    total++; if (n_ferr - bf !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - bf); end
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 4);
    total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL after_glitch_count: got %0d want 1", n_valid - bv); end
    total++; if (last_data !== 8'h3C) begin bad++; $display("FAIL after_glitch_data: got %h want 3c", last_data); end
  endtask

  task automatic test_frame_err();
    int bv, bf;
    bv = n_valid; bf = n_ferr;
    send_frame(8'hA3, 1'b0);
    hold(1'b0, 40);  // break: line stays low well past the frame
    total++; if (n_ferr - bf !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", n_ferr - bf); end
    total++; if (n_valid - bv !== 0) begin bad++; $display("FAIL ferr_valid: got %0d want 0", n_valid - bv); end
    hold(1'b1, 2);
    send_frame(8'h5A, 1'b1);
    hold(1'b1, 4);
    total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL post_break_count: got %0d want 1", n_valid - bv); end
    total++; if (last_data !== 8'h5A) begin bad++; $display("FAIL post_break_data: got %h want 5a", last_data); end
    total++; if (n_ferr - bf !== 1) begin bad++; $display("FAIL post_break_ferr: got %0d want 1", n_ferr - bf); end
  endtask

  task automatic test_overrun();
    int bv, bf, bo;
    bus.rx_ready = 1'b0;
    bv = n_valid; bf = n_ferr; bo = n_ovr;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    hold(1'b1, 4);
    total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h12) begin bad++; $display("FAIL ovr_data: got %h want 12", bus.rx_data); end
    total++; if (n_ovr - bo !== 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", n_ovr - bo); end
    total++; if (n_ferr - bf !== 0) begin bad++; $display("FAIL ovr_ferr: got %0d want 0", n_ferr - bf); end
    total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL ovr_rises: got %0d want 1", n_valid - bv); end
    @(negedge clk);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL accept_valid: got %b want 0", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h12) begin bad++; $display("FAIL accept_data: got %h want 12", bus.rx_data); end
  endtask

  task automatic test_reset_mid();
    int bv;
    bus.rx_ready = 1'b1;
    hold(1'b0, 16);
    repeat (4) hold(1'b1, 16);
    hold(1'b1, 8);  // middle of data bit 4 of 0xFF
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h want 00", bus.rx_data); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL midrst_ferr: got %b want 0", bus.frame_err); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL midrst_ovr: got %b want 0", bus.overrun); end
    @(negedge clk);
    rst = 1'b1;
    hold(1'b1, 8);
    bv = n_valid;
    send_frame(8'h0F, 1'b1);
    hold(1'b1, 4);
    total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL post_rst_count: got %0d want 1", n_valid - bv); end
    total++; if (last_data !== 8'h0F) begin bad++; $display("FAIL post_rst_data: got %h want 0f", last_data); end
  endtask

  task automatic test_majority();
    int bv;
    logic [7:0] exp_data;
`ifdef UART_RX_MAJORITY_EN
    exp_data = 8'h00;  // single-tick glitch is outvoted
`else
    exp_data = 8'h04;  // single-sample receiver takes the glitch as bit 2
`endif
    bus.rx_ready = 1'b1;
    bv = n_valid;
    hold(1'b0, 16);             // start
    hold(1'b0, 16);             // bit 0
    hold(1'b0, 16);             // bit 1
    hold(1'b0, 8);              // bit 2, up to the tick before its sample
    hold(1'b1, 1);              // high only on the bit-2 sample tick
    hold(1'b0, 7);
    repeat (5) hold(1'b0, 16);  // bits 3..7
    hold(1'b1, 16);             // stop
    hold(1'b1, 4);
    total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL glitch_bit2_count: got %0d want 1", n_valid - bv); end
    total++; if (last_data !== exp_data) begin bad++; $display("FAIL glitch_bit2_data: got %h want %h", last_data, exp_data); end
  endtask

  initial begin
    rst = 1'b0;
    rxd = 1'b1;
    bus.rx_ready = 1'b0;
    test_reset();
    test_frame();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_majority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
